// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM for a shared-memory multicycle CPU.
// Decoded instruction class is latched in DECODE so later steps ignore the IR contents.
module multicycle_controller #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               iord,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_sel,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src,
    output logic [2:0]         alu_op,
    output logic               busy,
    output logic               err,
    output logic [STATE_W-1:0] state
);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_WB     = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(7);

    // R-type ALU classes are numbered so their low bits equal the ALU op code
    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_XOR  = 4'd2;
    localparam logic [3:0] C_SLT  = 4'd3;
    localparam logic [3:0] C_ADDI = 4'd4;
    localparam logic [3:0] C_XORI = 4'd5;
    localparam logic [3:0] C_LW   = 4'd6;
    localparam logic [3:0] C_SW   = 4'd7;
    localparam logic [3:0] C_BEQ  = 4'd8;
    localparam logic [3:0] C_BNE  = 4'd9;
    localparam logic [3:0] C_J    = 4'd10;
    localparam logic [3:0] C_JAL  = 4'd11;
    localparam logic [3:0] C_JR   = 4'd12;
    localparam logic [3:0] C_ILL  = 4'd13;

    function automatic logic [3:0] classify(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        logic [3:0] c;
        c = C_ILL;
        case (op)
            OP_W'('h00): case (fn)
                OP_W'('h20): c = C_ADD;
                OP_W'('h22): c = C_SUB;
                OP_W'('h26): c = C_XOR;
                OP_W'('h2A): c = C_SLT;
                OP_W'('h08): c = C_JR;
                default:     c = C_ILL;
            endcase
            OP_W'('h08): c = C_ADDI;
            OP_W'('h0E): c = C_XORI;
            OP_W'('h23): c = C_LW;
            OP_W'('h2B): c = C_SW;
            OP_W'('h04): c = C_BEQ;
            OP_W'('h05): c = C_BNE;
            OP_W'('h02): c = C_J;
            OP_W'('h03): c = C_JAL;
            default:     c = C_ILL;
        endcase
        return c;
    endfunction

    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         cls_q, cls_d, dec_cls;
    logic               is_r, is_wb, is_br;

    assign is_r  = cls_q <= C_SLT;
    assign is_wb = cls_q <= C_XORI;
    assign is_br = (cls_q == C_BEQ) || (cls_q == C_BNE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILL;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        dec_cls = classify(opcode, funct);
        cls_d   = (state_q == S_DECODE) ? dec_cls : cls_q;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC:   state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : is_wb ? S_WB : S_FETCH;
            S_MEM:    state_d = !mem_ready ? S_MEM : (cls_q == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset is also applied combinationally so every enable drops the instant it rises
    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        iord    = 1'b0;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        pc_sel  = 2'b00;
        reg_wr  = 1'b0;
        reg_dst = 2'b00;
        wb_sel  = 2'b00;
        alu_src = 1'b0;
        alu_op  = 3'b000;
        if (!reset && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
            alu_src = cls_q inside {C_ADDI, C_XORI, C_LW, C_SW};
            alu_op  = is_r ? cls_q[2:0] : (cls_q == C_XORI) ? 3'b010 : is_br ? 3'b001 : 3'b000;
        end
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    ir_wr  = mem_ready;
                    pc_wr  = mem_ready;
                end
                S_EXEC: begin
                    pc_wr   = (cls_q == C_BEQ) ? zero : (cls_q == C_BNE) ? ~zero : (cls_q inside {C_J, C_JAL, C_JR});
                    pc_sel  = is_br ? 2'b01 : (cls_q == C_J || cls_q == C_JAL) ? 2'b10 : (cls_q == C_JR) ? 2'b11 : 2'b00;
                    reg_wr  = cls_q == C_JAL;
                    reg_dst = (cls_q == C_JAL) ? 2'b10 : 2'b00;
                    wb_sel  = (cls_q == C_JAL) ? 2'b10 : 2'b00;
                end
                S_MEM: begin
                    iord   = 1'b1;
                    mem_rd = cls_q == C_LW;
                    mem_wr = cls_q == C_SW;
                end
                S_WB: begin
                    reg_wr  = 1'b1;
                    reg_dst = is_r ? 2'b01 : 2'b00;
                    wb_sel  = (cls_q == C_LW) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign busy  = state_q != S_FETCH;
    assign err   = state_q == S_TRAP;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle expectations for each instruction class,
// queued as stimulus steps and checked against the controller outputs on the falling edge.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_rd, mem_wr, iord, ir_wr, pc_wr, reg_wr, alu_src, busy, err;
    logic [1:0] pc_sel, reg_dst, wb_sel;
    logic [2:0] alu_op, state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
        .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       rd, wr, io, irw, pcw;
        logic [1:0] ps;
        logic       rw;
        logic [1:0] rdst, wbs;
        logic       as;
        logic [2:0] ao;
        logic       bz, er;
    } exp_t;

    typedef struct {
        logic rdy;
        logic z;
        exp_t e;
    } step_t;

    exp_t  sb[$];
    step_t prog[$];
    int    total = 0, bad = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic rd, wr, io, irw, pcw,
                                input logic [1:0] ps, input logic rw, input logic [1:0] rdst, wbs,
                                input logic as, input logic [2:0] ao, input logic bz, er);
        return {st, rd, wr, io, irw, pcw, ps, rw, rdst, wbs, as, ao, bz, er};
    endfunction

    function automatic exp_t fe(input logic rdy);
        return mk(0, 1, 0, 0, rdy, rdy, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
    endfunction

    function automatic exp_t de();
        return mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0);
    endfunction

    function automatic exp_t tr();
        return mk(7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 1, 1);
    endfunction

    function automatic exp_t zr();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
    endfunction

    task automatic chk(input string tag);
        exp_t e, a;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        a = {state, mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_sel, reg_wr, reg_dst, wb_sel,
             alu_src, alu_op, busy, err};
        assert (a === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, a, e);
        end
    endtask

    task automatic add(input logic rdy, input logic z, input exp_t e);
        step_t s;
        s.rdy = rdy;
        s.z   = z;
        s.e   = e;
        prog.push_back(s);
    endtask

    task automatic run(input string tag);
        step_t s;
        int    n;
        n = 0;
        while (prog.size() > 0) begin
            s = prog.pop_front();
            mem_ready = s.rdy;
            zero      = s.z;
            sb.push_back(s.e);
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, n));
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        #1;
        sb.push_back(zr());
        chk(tag);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [2:0] ao);
        instr(6'h00, fn);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, ao, 1, 0));
        add(1, 0, mk(4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, ao, 1, 0));
        run(tag);
    endtask

    task automatic ctl3(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input exp_t ex);
        instr(op, fn);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, z, ex);
        run(tag);
    endtask

    initial begin
        #12;
        sb.push_back(zr());
        chk("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        rtype("add", 6'h20, 3'b000);
        rtype("sub", 6'h22, 3'b001);
        rtype("xor", 6'h26, 3'b010);
        rtype("slt", 6'h2A, 3'b011);

        instr(6'h08, 6'h3F);
        add(0, 0, fe(0));
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(1, 0, mk(4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        run("addi");

        instr(6'h0E, 6'h00);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 1, 0));
        add(1, 0, mk(4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b010, 1, 0));
        run("xori");

        instr(6'h23, 6'h00);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(0, 0, mk(3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(0, 0, mk(3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(1, 0, mk(3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(1, 0, mk(4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 1, 3'b000, 1, 0));
        run("lw");

        instr(6'h2B, 6'h00);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(1, 0, mk(3, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        run("sw");

        ctl3("beq_t", 6'h04, 6'h00, 1, mk(2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 1, 0));
        ctl3("beq_n", 6'h04, 6'h00, 0, mk(2, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 1, 0));
        ctl3("bne_t", 6'h05, 6'h00, 0, mk(2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 1, 0));
        ctl3("bne_n", 6'h05, 6'h00, 1, mk(2, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 1, 0));
        ctl3("j",     6'h02, 6'h00, 0, mk(2, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
        ctl3("jal",   6'h03, 6'h00, 0, mk(2, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 3'b000, 1, 0));
        ctl3("jr",    6'h00, 6'h08, 0, mk(2, 0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));

        instr(6'h3F, 6'h20);
        add(1, 0, fe(1));
        add(1, 0, de());
        for (int i = 0; i < 10; i++) add(i[0], i[1], tr());
        run("trap_op");
        reset_check("trap_op_rst");

        instr(6'h00, 6'h3F);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, tr());
        add(0, 0, tr());
        run("trap_fn");
        reset_check("trap_fn_rst");

        instr(6'h2B, 6'h00);
        add(1, 0, fe(1));
        add(1, 0, de());
        add(1, 0, mk(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        add(0, 0, mk(3, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 1, 0));
        run("sw_abort");
        #2;
        reset_check("sw_abort_rst");

        rtype("add_after", 6'h20, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
